mips_muldiv_unit: RTL and testbench

Sequential multiply/divide unit for the MIPS CPU. It owns the HI/LO register pair and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO as a multi-cycle companion to the single-cycle ALU. The execute stage issues operations through a start/busy/done handshake and stalls on `mdu_busy`. MFHI and MFLO read `mdu_hi` and `mdu_lo` directly.

---
 rtl/mips_muldiv_unit_pkg.sv | 30 +++
 rtl/mips_muldiv_unit_step.sv | 42 ++++
 rtl/mips_muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_unit_pkg.sv
// +--------------------------------------------------------------------+
// | mips_muldiv_unit_pkg : opcodes, FSM states and helpers for the MDU  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package mips_muldiv_unit_pkg;

   localparam logic [2:0] MDU_MULT  = 3'd0;
   localparam logic [2:0] MDU_MULTU = 3'd1;
   localparam logic [2:0] MDU_DIV   = 3'd2;
   localparam logic [2:0] MDU_DIVU  = 3'd3;
   localparam logic [2:0] MDU_MTHI  = 3'd4;
   localparam logic [2:0] MDU_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

   // Magnitude of a signed operand; the most negative value maps to 2^31 as unsigned.
   function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mips_muldiv_unit_step.sv
// +--------------------------------------------------------------------+
// | mdu_step : one radix-2 iteration (shift-add multiply or restoring   |
// | shift-subtract divide).                              Revision: 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module mdu_step (
   input  logic        mode_i,
   input  logic [63:0] acc_i,
   input  logic [31:0] operand_i,
   output logic [63:0] acc_o
);

   logic [32:0] w_sum;
   logic [32:0] w_rem_sh;
   logic        w_borrow;
   logic [31:0] w_diff;

   // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
   assign w_sum    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, operand_i} : 33'd0);

   // Divide: acc = {remainder, quotient}; shift left and try to subtract the divisor.
   assign w_rem_sh = acc_i[63:31];
   assign w_borrow = (w_rem_sh < {1'b0, operand_i});
   assign w_diff   = w_rem_sh[31:0] - operand_i;

   always_comb begin
      acc_o = acc_i;
      if (mode_i) begin
         if (w_borrow) begin
            acc_o = {w_rem_sh[31:0], acc_i[30:0], 1'b0};
         end else begin
            acc_o = {w_diff, acc_i[30:0], 1'b1};
         end
      end else begin
         acc_o = {w_sum, acc_i[31:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
// +--------------------------------------------------------------------+
// | mips_muldiv_unit : sequential HI/LO multiply/divide unit.           |
// | Option MDU_FAST_MULT_EN: single-cycle '*' multiply. Revision: 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module mips_muldiv_unit
   import mips_muldiv_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  mdu_opcode,
   input  logic        mdu_start,
   input  logic [31:0] mdu_op_x,
   input  logic [31:0] mdu_op_y,
   output logic        mdu_busy,
   output logic        mdu_done,
   output logic [31:0] mdu_hi,
   output logic [31:0] mdu_lo
);

   mdu_state_t  state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        divz_q, divz_d;

   logic        w_signed;
   logic        w_div;
   logic [31:0] w_mag_x;
   logic [31:0] w_mag_y;
   logic [63:0] w_step_acc;
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   assign w_signed = (mdu_opcode == MDU_MULT) || (mdu_opcode == MDU_DIV);
   assign w_div    = (mdu_opcode == MDU_DIV)  || (mdu_opcode == MDU_DIVU);
   assign w_mag_x  = mdu_mag(mdu_op_x, w_signed);
   assign w_mag_y  = mdu_mag(mdu_op_y, w_signed);

`ifdef MDU_FAST_MULT_EN
   logic [63:0] w_fast_prod;
   assign w_fast_prod = {32'd0, w_mag_x} * {32'd0, w_mag_y};
`endif

   mdu_step u_step (
      .mode_i    (is_div_q),
      .acc_i     (acc_q),
      .operand_i (opnd_q),
      .acc_o     (w_step_acc)
   );

   assign w_prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
   assign w_quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign w_rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      divz_d    = divz_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (mdu_start) begin
               case (mdu_opcode)
                  MDU_MTHI: begin
                     hi_d    = mdu_op_x;
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end
                  MDU_MTLO: begin
                     lo_d    = mdu_op_x;
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end
                  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                     is_div_d  = w_div;
                     neg_res_d = w_signed && (mdu_op_x[31] ^ mdu_op_y[31]);
                     neg_rem_d = w_signed && mdu_op_x[31];
                     divz_d    = w_div && (mdu_op_y == 32'd0);
                     cnt_d     = 5'd0;
                     busy_d    = 1'b1;
                     state_d   = ST_CALC;
                     if (w_div) begin
                        // A zero divisor preloads the final HI/LO and the steps are suppressed.
                        acc_d  = (mdu_op_y == 32'd0) ? {mdu_op_x, 32'hFFFF_FFFF}
                                                     : {32'd0, w_mag_x};
                        opnd_d = w_mag_y;
                     end else begin
                        acc_d  = {32'd0, w_mag_y};
                        opnd_d = w_mag_x;
`ifdef MDU_FAST_MULT_EN
                        acc_d   = w_fast_prod;
                        state_d = ST_FIX;
`endif
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_CALC: begin
            if (!divz_q) begin
               acc_d = w_step_acc;
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (divz_q) begin
               hi_d = acc_q[63:32];
               lo_d = acc_q[31:0];
            end else if (is_div_q) begin
               hi_d = w_rem_fix;
               lo_d = w_quo_fix;
            end else begin
               hi_d = w_prod_fix[63:32];
               lo_d = w_prod_fix[31:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         acc_q     <= 64'd0;
         opnd_q    <= 32'd0;
         cnt_q     <= 5'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         divz_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         divz_q    <= divz_d;
      end
   end

   assign mdu_busy = busy_q;
   assign mdu_done = done_q;
   assign mdu_hi   = hi_q;
   assign mdu_lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
// +--------------------------------------------------------------------+
// | tb_mips_muldiv_unit : directed self-checking bench for the MDU.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mips_muldiv_unit;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MDU_FAST_MULT_EN
   localparam int MUL_BUSY = 1;
   localparam int MUL_DONE = 2;
`else
   localparam int MUL_BUSY = 33;
   localparam int MUL_DONE = 34;
`endif

   logic        clk;
   logic        rst;
   logic [2:0]  mdu_opcode;
   logic        mdu_start;
   logic [31:0] mdu_op_x;
   logic [31:0] mdu_op_y;
   logic        mdu_busy;
   logic        mdu_done;
   logic [31:0] mdu_hi;
   logic [31:0] mdu_lo;

   int checks   = 0;
   int failures = 0;

   mips_muldiv_unit dut (
      .clk        (clk),
      .rst        (rst),
      .mdu_opcode (mdu_opcode),
      .mdu_start  (mdu_start),
      .mdu_op_x   (mdu_op_x),
      .mdu_op_y   (mdu_op_y),
      .mdu_busy   (mdu_busy),
      .mdu_done   (mdu_done),
      .mdu_hi     (mdu_hi),
      .mdu_lo     (mdu_lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drive a start at the current negedge; returns at the negedge of cycle 1.
   task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      mdu_opcode = op;
      mdu_op_x   = x;
      mdu_op_y   = y;
      mdu_start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mdu_start  = 1'b0;
   endtask

   // Watches from cycle 1 until done; optionally injects a stray start at cycle int_cyc.
   task automatic watch(input string tag, input int exp_busy, input int exp_done,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int int_cyc);
      int  cyc;
      int  busy_n;
      int  first_busy;
      int  done_cyc;
      logic intr;
      cyc = 1; busy_n = 0; first_busy = 0; done_cyc = 0; intr = 1'b0;
      while (done_cyc == 0 && cyc <= 60) begin
         if (intr) begin
            mdu_start = 1'b0;
            intr      = 1'b0;
         end
         if (mdu_busy) begin
            busy_n++;
            if (first_busy == 0) first_busy = cyc;
         end
         if (mdu_done) begin
            done_cyc = cyc;
         end else begin
            if (cyc == int_cyc) begin
               mdu_opcode = OP_DIVU;
               mdu_op_x   = 32'd5;
               mdu_op_y   = 32'd1;
               mdu_start  = 1'b1;
               intr       = 1'b1;
            end
            @(negedge clk);
            cyc++;
         end
      end
      mdu_start = 1'b0;
      check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
      check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
      if (exp_busy > 0) check({tag, "_busy_first"}, 64'(first_busy), 64'd1);
      check({tag, "_hi"}, {32'd0, mdu_hi}, {32'd0, exp_hi});
      check({tag, "_lo"}, {32'd0, mdu_lo}, {32'd0, exp_lo});
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int eb, input int ed,
                        input logic [31:0] ehi, input logic [31:0] elo, input int int_cyc);
      @(negedge clk);
      issue(op, x, y);
      watch(tag, eb, ed, ehi, elo, int_cyc);
   endtask

   initial begin
      rst        = 1'b1;
      mdu_start  = 1'b0;
      mdu_opcode = 3'd0;
      mdu_op_x   = 32'd0;
      mdu_op_y   = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", {63'd0, mdu_busy}, 64'd0);
      check("rst_done", {63'd0, mdu_done}, 64'd0);
      check("rst_hi", {32'd0, mdu_hi}, 64'd0);
      check("rst_lo", {32'd0, mdu_lo}, 64'd0);

      do_op("mult_neg", OP_MULT, 32'd7, 32'hFFFF_FFFD, MUL_BUSY, MUL_DONE,
            32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
      do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_BUSY, MUL_DONE,
            32'hFFFF_FFFE, 32'h0000_0001, 0);
      do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 34,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
      do_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 33, 34,
            32'h0000_0064, 32'hFFFF_FFFF, 0);
      do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 34,
            32'h0000_0000, 32'h8000_0000, 0);
      do_op("mthi", OP_MTHI, 32'h1234_5678, 32'd0, 0, 1,
            32'h1234_5678, 32'h8000_0000, 0);
      do_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0, 0, 1,
            32'h1234_5678, 32'hCAFE_F00D, 0);

      // Stray start at cycle 10 must be ignored: 1000 / 7 = 142 rem 6.
      do_op("divu_busy_start", OP_DIVU, 32'd1000, 32'd7, 33, 34,
            32'd6, 32'd142, 10);
      // Issue in the DONE cycle of the previous op.
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
      watch("divu_b2b", 33, 34, 32'h0000_000F, 32'h0FFF_FFFF, 0);

      @(negedge clk);
      issue(OP_MULT, 32'd7, 32'd3);
      repeat (14) @(negedge clk);
      check("pre_rst_busy", {63'd0, mdu_busy}, 64'd1);
      rst = 1'b1;
      #1;
      check("arst_busy", {63'd0, mdu_busy}, 64'd0);
      check("arst_done", {63'd0, mdu_done}, 64'd0);
      check("arst_hi", {32'd0, mdu_hi}, 64'd0);
      check("arst_lo", {32'd0, mdu_lo}, 64'd0);
      #1;
      rst = 1'b0;
      do_op("mult_after_rst", OP_MULT, 32'd7, 32'd3, MUL_BUSY, MUL_DONE,
            32'd0, 32'd21, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
